trace_uart_tx: RTL and testbench

- Synthesizable hardware counterpart of the bench-side pc/instr trace dump for the 54-instruction CPU.
- Captures one (pc, inst) record per retired instruction into a small FIFO.
- Serializes each record as a framed byte stream on a UART 8N1 transmitter, so a host can reconstruct the execution trace from a board run.
- Sits beside sccomp_dataflow and taps its pc/inst outputs.

---
 rtl/trace_pkg.sv | 22 ++
 rtl/trace_uart_tx_if.sv | 12 +
 rtl/trace_fifo.sv | 43 ++++
 rtl/trace_uart_tx.sv | 159 +++++++++++++++
 tb/tb_trace_uart_tx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// Shared constants, frame helpers and FSM encoding for the trace UART transmitter.
package trace_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int FRAME_BYTES = 9;
    localparam int FRAME_BITS  = FRAME_BYTES * 8;
    localparam int REC_WIDTH   = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // A frame is the sync byte followed by the {pc, inst} record, most significant byte first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] sync,
                                                          input logic [REC_WIDTH-1:0] rec);
        return {sync, rec};
    endfunction

endpackage

// File: rtl/trace_uart_tx_if.sv
// Capture-side bundle: the retired-instruction strobe, its pc/inst and the capture gate.
interface trace_uart_tx_if;

    logic        trace_valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        enable;

    modport master (output trace_valid, pc, inst, enable);
    modport slave  (input  trace_valid, pc, inst, enable);

endinterface

// File: rtl/trace_fifo.sv
// Small synchronous FIFO with extra-MSB pointers so full and empty fall out of a compare.
module trace_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Advance the read and write pointers; the caller never pushes into a full FIFO without a pop.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/trace_uart_tx.sv
// Captures retired (pc, inst) records and streams them as 9-byte 8N1 UART frames.
module trace_uart_tx
    import trace_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          MAX_RECORDS  = 10000,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic               clk_in,
    input  logic               reset,
    trace_uart_tx_if.slave     trc,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        rec_cnt
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] REC_LIMIT   = 16'(MAX_RECORDS);
    localparam logic [3:0]  LAST_BYTE   = 4'(FRAME_BYTES - 1);

    tx_state_t             state;
    logic [15:0]           baud_cnt;
    logic [2:0]            bit_idx;
    logic [3:0]            byte_idx;
    logic [FRAME_BITS-1:0] shift_reg;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [REC_WIDTH-1:0]  fifo_dout;
    logic                  accept;
    logic                  drop;
    logic                  bit_end;
    logic [7:0]            cur_byte;
    logic [2:0]            next_bit;

    trace_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    ({trc.pc, trc.inst}),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Decide push/pop/drop for this edge; a pop frees a slot so a full FIFO can still take a record.
    always_comb begin
        bit_end  = (baud_cnt == 16'd0);
        cur_byte = shift_reg[FRAME_BITS-1 -: 8];
        next_bit = bit_idx + 3'd1;
        fifo_pop = !fifo_empty &&
                   ((state == ST_IDLE) ||
                    (state == ST_STOP && bit_end && byte_idx == LAST_BYTE));
        accept    = trc.trace_valid && trc.enable && (rec_cnt < REC_LIMIT);
        fifo_push = accept && (!fifo_full || fifo_pop);
        drop      = accept && fifo_full && !fifo_pop;
    end

    assign busy = !fifo_empty || (state != ST_IDLE);

    // Track accepted and dropped records; the drop counter saturates rather than wrapping.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            rec_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
            overflow <= 1'b0;
        end else begin
            if (fifo_push) rec_cnt <= rec_cnt + 16'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // UART framing FSM: start bit, eight data bits LSB first, stop bit; frames chain back to back.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= 16'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 4'd0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (fifo_pop) begin
                        shift_reg <= build_frame(SYNC_BYTE, fifo_dout);
                        byte_idx  <= 4'd0;
                        baud_cnt  <= BAUD_RELOAD;
                        tx        <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        bit_idx  <= 3'd0;
                        tx       <= cur_byte[0];
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_RELOAD;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx  <= byte_idx + 4'd1;
                            shift_reg <= {shift_reg[FRAME_BITS-9:0], 8'h00};
                            tx        <= 1'b0;
                            state     <= ST_START;
                        end else if (fifo_pop) begin
                            shift_reg <= build_frame(SYNC_BYTE, fifo_dout);
                            byte_idx  <= 4'd0;
                            tx        <= 1'b0;
                            state     <= ST_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_uart_tx.sv
// Directed bench: drives trace strobes, decodes the UART line and scoreboards the frames.
module tb_trace_uart_tx;

    localparam int CPB         = 4;
    localparam int DEPTH       = 4;
    localparam int BYTE_CYCLES = CPB * 10;
    localparam int FRAME_CYC   = CPB * 90;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Edge counter used to timestamp captures and start bits.
    always @(posedge clk) cyc <= cyc + 1;

    trace_uart_tx_if bus_main ();
    trace_uart_tx_if bus_lim ();

    logic        tx_main, busy_main, ovf_main;
    logic [15:0] drop_main, rec_main;
    logic        tx_lim, busy_lim, ovf_lim;
    logic [15:0] drop_lim, rec_lim;

    trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_main (
        .clk_in (clk), .reset (rst_n), .trc (bus_main),
        .tx (tx_main), .busy (busy_main), .overflow (ovf_main),
        .drop_cnt (drop_main), .rec_cnt (rec_main)
    );

    trace_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .MAX_RECORDS(2)) dut_lim (
        .clk_in (clk), .reset (rst_n), .trc (bus_lim),
        .tx (tx_lim), .busy (busy_lim), .overflow (ovf_lim),
        .drop_cnt (drop_lim), .rec_cnt (rec_lim)
    );

    int         tests_run = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];
    int         start_q0 [$];
    int         framing_err [2];
    int         rx_n [2];
    bit         rx_act [2];
    logic [7:0] rx_sh [2];
    int         cap_cyc;

    // UART receivers for both DUTs, sampling mid-bit on falling clock edges.
    initial begin : uart_monitor
        logic t;
        int   k;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                t = (w == 0) ? tx_main : tx_lim;
                if (!rst_n) begin
                    rx_act[w] = 1'b0;
                end else if (!rx_act[w]) begin
                    if (t == 1'b0) begin
                        rx_act[w] = 1'b1;
                        rx_n[w]   = 0;
                        if (w == 0) start_q0.push_back(cyc);
                    end
                end else begin
                    rx_n[w]++;
                    if (rx_n[w] >= CPB + CPB / 2 && (rx_n[w] - CPB / 2) % CPB == 0) begin
                        k = (rx_n[w] - CPB / 2) / CPB - 1;
                        if (k < 8) begin
                            rx_sh[w][k[2:0]] = t;
                        end else begin
                            if (t !== 1'b1) framing_err[w]++;
                            if (w == 0) rx_q0.push_back(rx_sh[w]);
                            else        rx_q1.push_back(rx_sh[w]);
                            rx_act[w] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Hard stop in case something upstream hangs.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input int w, input logic [31:0] p, input logic [31:0] i,
                                  input bit accepted);
        logic [71:0] f;
        f = {8'hA5, p, i};
        if (w == 0) begin
            bus_main.trace_valid = 1'b1; bus_main.pc = p; bus_main.inst = i;
        end else begin
            bus_lim.trace_valid = 1'b1; bus_lim.pc = p; bus_lim.inst = i;
        end
        if (accepted) begin
            for (int b = 0; b < 9; b++) begin
                if (w == 0) exp_q0.push_back(f[71 - 8 * b -: 8]);
                else        exp_q1.push_back(f[71 - 8 * b -: 8]);
            end
        end
        @(posedge clk);
        #1;
        cap_cyc = cyc;
        bus_main.trace_valid = 1'b0;
        bus_lim.trace_valid  = 1'b0;
    endtask

    task automatic wait_idle(input int w, output int drop_cyc);
        bit b;
        b = 1'b1;
        drop_cyc = -1;
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            b = (w == 0) ? busy_main : busy_lim;
            if (!b) begin
                drop_cyc = cyc;
                break;
            end
        end
        check_output("busy_settled", 32'(b), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare_frames(input int w, input string tag);
        logic [7:0] got, want;
        if (w == 0) begin
            check_output({tag, "_bytes"}, rx_q0.size(), exp_q0.size());
            while (rx_q0.size() > 0 && exp_q0.size() > 0) begin
                got = rx_q0.pop_front(); want = exp_q0.pop_front();
                check_output({tag, "_data"}, 32'(got), 32'(want));
            end
        end else begin
            check_output({tag, "_bytes"}, rx_q1.size(), exp_q1.size());
            while (rx_q1.size() > 0 && exp_q1.size() > 0) begin
                got = rx_q1.pop_front(); want = exp_q1.pop_front();
                check_output({tag, "_data"}, 32'(got), 32'(want));
            end
        end
        check_output({tag, "_stop"}, framing_err[w], 0);
        rx_q0.delete(); rx_q1.delete(); exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic clear_scoreboard();
        rx_q0.delete(); rx_q1.delete(); exp_q0.delete(); exp_q1.delete();
        start_q0.delete();
        framing_err[0] = 0;
        framing_err[1] = 0;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_scoreboard();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        int first_cap;
        int drop_cyc;
        int fall;

        rst_n = 1'b0;
        bus_main.trace_valid = 1'b0; bus_main.pc = '0; bus_main.inst = '0; bus_main.enable = 1'b1;
        bus_lim.trace_valid  = 1'b0; bus_lim.pc  = '0; bus_lim.inst  = '0; bus_lim.enable  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_tx",   32'(tx_main),   32'd1);
        check_output("reset_busy", 32'(busy_main), 32'd0);
        check_output("reset_ovf",  32'(ovf_main),  32'd0);
        check_output("reset_drop", 32'(drop_main), 32'd0);
        check_output("reset_rec",  32'(rec_main),  32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single record: latency, length and payload.
        apply_stimulus(0, 32'h00400000, 32'h3C011001, 1'b1);
        first_cap = cap_cyc;
        wait_idle(0, drop_cyc);
        check_output("single_starts", start_q0.size(), 9);
        if (start_q0.size() > 0) begin
            check_output("single_tx_fall",  start_q0[0], first_cap + 1);
            check_output("single_busy_len", drop_cyc - start_q0[0], FRAME_CYC);
        end
        check_output("single_rec", 32'(rec_main), 32'd1);
        compare_frames(0, "single");

        // Back-to-back strobes: three frames with no idle gap.
        do_reset();
        apply_stimulus(0, 32'h00400004, 32'h24020005, 1'b1);
        apply_stimulus(0, 32'h00400008, 32'h00432021, 1'b1);
        apply_stimulus(0, 32'h0040000C, 32'hAC040000, 1'b1);
        wait_idle(0, drop_cyc);
        check_output("b2b_starts", start_q0.size(), 27);
        for (int k = 1; k < start_q0.size(); k++)
            check_output("b2b_gap", start_q0[k] - start_q0[k-1], BYTE_CYCLES);
        check_output("b2b_rec", 32'(rec_main), 32'd3);
        compare_frames(0, "b2b");

        // Overflow: six strobes into a depth-4 FIFO, the last one is dropped.
        do_reset();
        for (int k = 0; k < 6; k++)
            apply_stimulus(0, 32'h00400100 + 32'(4 * k), 32'h20080000 + 32'(k), k < 5);
        wait_idle(0, drop_cyc);
        check_output("ovf_flag", 32'(ovf_main),  32'd1);
        check_output("ovf_drop", 32'(drop_main), 32'd1);
        check_output("ovf_rec",  32'(rec_main),  32'd5);
        compare_frames(0, "ovf");

        // Record limit of two: the third strobe is ignored, not dropped.
        do_reset();
        for (int k = 0; k < 3; k++)
            apply_stimulus(1, 32'h00400300 + 32'(4 * k), 32'h3C080000 + 32'(k), k < 2);
        wait_idle(1, drop_cyc);
        check_output("limit_rec",  32'(rec_lim),  32'd2);
        check_output("limit_drop", 32'(drop_lim), 32'd0);
        check_output("limit_ovf",  32'(ovf_lim),  32'd0);
        compare_frames(1, "limit");

        // Asynchronous reset during the data bits of byte 3.
        do_reset();
        apply_stimulus(0, 32'h00400200, 32'h8C090000, 1'b1);
        fall = cap_cyc + 1;
        while (cyc < fall + 3 * BYTE_CYCLES + 8) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_output("arst_tx",   32'(tx_main),   32'd1);
        check_output("arst_busy", 32'(busy_main), 32'd0);
        check_output("arst_rec",  32'(rec_main),  32'd0);
        check_output("arst_drop", 32'(drop_main), 32'd0);
        check_output("arst_ovf",  32'(ovf_main),  32'd0);
        @(posedge clk);
        #1;
        clear_scoreboard();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_stimulus(0, 32'h00400204, 32'h01095020, 1'b1);
        wait_idle(0, drop_cyc);
        compare_frames(0, "fresh");

        // Capture gated off: nothing sent or counted until re-enabled.
        bus_main.enable = 1'b0;
        apply_stimulus(0, 32'h00400208, 32'h11200002, 1'b0);
        apply_stimulus(0, 32'h0040020C, 32'h00000000, 1'b0);
        repeat (60) @(negedge clk);
        check_output("disabled_busy", 32'(busy_main), 32'd0);
        check_output("disabled_rec",  32'(rec_main),  32'd1);
        compare_frames(0, "disabled");
        bus_main.enable = 1'b1;
        apply_stimulus(0, 32'h00400210, 32'h08100000, 1'b1);
        wait_idle(0, drop_cyc);
        check_output("reenable_rec", 32'(rec_main), 32'd2);
        compare_frames(0, "reenable");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
